// File: rtl/rr_sreg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rr_sreg_pkg
//  Description : Shared definitions for the round-robin shared-register
//                arbiter: index-width helper, requester limit and the
//                pipeline stage record {valid, id, data}.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================

// The stage record depends on per-instance widths, so it is provided as a
// macro that each user expands with its own DATAWIDTH / IDW.
`ifndef RR_SREG_STAGE_T
`define RR_SREG_STAGE_T(DW, IW) struct packed { logic valid; logic [(IW)-1:0] id; logic signed [(DW)-1:0] data; }
`endif

package rr_sreg_pkg;

    localparam int MAX_NREQ = 16;

    // Requester index width; at least one bit even for degenerate counts.
    function automatic int rr_idw(input int nreq);
        return (nreq <= 2) ? 1 : $clog2(nreq);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin pick. Rotates Req so that Ptr
//                lands at bit 0, priority-encodes the lowest set bit, then
//                rotates the result back to an absolute requester index.
//  Ports       : Req   in  NREQ  request vector
//                Ptr   in  IDW   first requester to consider
//                Gnt   out NREQ  one-hot pick (zero when no request)
//                GntId out IDW   binary index of the pick (meaningful only
//                                when Gnt is non-zero)
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick
    import rr_sreg_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = rr_idw(NREQ)
) (
    input  logic [NREQ-1:0] Req,
    input  logic [IDW-1:0]  Ptr,
    output logic [NREQ-1:0] Gnt,
    output logic [IDW-1:0]  GntId
);

    logic [NREQ-1:0] w_rot;
    logic [IDW-1:0]  w_off;
    logic [IDW:0]    w_sum;

    always_comb begin
        // Rotate right by Ptr; when Ptr is 0 the left shift by NREQ clears.
        w_rot = (Req >> Ptr) | (Req << (NREQ - int'(Ptr)));

        // Lowest set bit of the rotated vector wins (descending scan).
        w_off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IDW'(k);
            end
        end

        // Rotate back: both terms are < NREQ, so one conditional subtract
        // gives the modulo even for non-power-of-two NREQ.
        w_sum = {1'b0, Ptr} + {1'b0, w_off};
        if (w_sum >= (IDW+1)'(NREQ)) begin
            w_sum = w_sum - (IDW+1)'(NREQ);
        end

        GntId = w_sum[IDW-1:0];
        Gnt   = (|Req) ? (NREQ'(1) << GntId) : '0;
    end

endmodule

`default_nettype wire

// File: rtl/rr_sreg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_sreg_arbiter
//  Description : Round-robin arbiter that shares one LATENCY-deep signed
//                register chain between NREQ requesters. At most one grant
//                per cycle; the granted operand travels down the chain
//                tagged with its requester index and is presented with
//                valid/ready back-pressure.
//  Ports       : Clk       in  1               clock (rising edge)
//                Rst       in  1               async reset, active-high
//                Req       in  NREQ            per-requester request
//                ReqData   in  NREQ*DATAWIDTH  packed signed operands
//                Gnt       out NREQ            one-hot grant (combinational)
//                OutValid  out 1               result valid
//                OutReady  in  1               downstream accept
//                OutId     out IDW             owner of OutData
//                OutData   out DATAWIDTH       signed result
//  Revision    : 1.0  initial release
// ============================================================================
module rr_sreg_arbiter
    import rr_sreg_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int NREQ      = 4,
    parameter int LATENCY   = 2,
    parameter int IDW       = rr_idw(NREQ)
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic [NREQ-1:0]             Req,
    input  logic [NREQ*DATAWIDTH-1:0]   ReqData,
    output logic [NREQ-1:0]             Gnt,
    output logic                        OutValid,
    input  logic                        OutReady,
    output logic [IDW-1:0]              OutId,
    output logic signed [DATAWIDTH-1:0] OutData
);

    typedef `RR_SREG_STAGE_T(DATAWIDTH, IDW) stage_t;

    logic [IDW-1:0]              r_ptr;
    logic [NREQ-1:0]             w_pick_gnt;
    logic [IDW-1:0]              w_pick_id;
    logic                        w_adv;
    logic                        w_fire;
    logic signed [DATAWIDTH-1:0] w_sel_data;
    stage_t                      w_load;
    stage_t                      w_stage [LATENCY];

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .Req   (Req),
        .Ptr   (r_ptr),
        .Gnt   (w_pick_gnt),
        .GntId (w_pick_id)
    );

    // The whole chain advances unless a valid head is being refused; a
    // bubble at the head never blocks. Rst is included so no grant is
    // shown while reset is held.
    assign w_adv  = ~(OutValid & ~OutReady) & ~Rst;
    assign Gnt    = w_adv ? w_pick_gnt : '0;
    assign w_fire = |Gnt;

    // Constant-index mux avoids a variable part-select on the packed bus.
    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_pick_gnt[k]) begin
                w_sel_data = ReqData[k*DATAWIDTH +: DATAWIDTH];
            end
        end
        w_load.valid = w_fire;
        w_load.id    = w_pick_id;
        w_load.data  = w_sel_data;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_ptr <= '0;
        end else if (w_fire) begin
            r_ptr <= (w_pick_id == IDW'(NREQ - 1)) ? '0 : w_pick_id + IDW'(1);
        end
    end

    // Register chain: bubbles are carried like items, so holding the
    // whole chain on a stall keeps order and spacing intact.
    for (genvar s = 0; s < LATENCY; s++) begin : g_stage
        stage_t r_q;
        stage_t w_d;

        if (s == 0) begin : g_head
            assign w_d = w_load;
        end else begin : g_body
            assign w_d = w_stage[s-1];
        end

        always_ff @(posedge Clk or posedge Rst) begin
            if (Rst) begin
                r_q <= '0;
            end else if (w_adv) begin
                r_q <= w_d;
            end
        end

        assign w_stage[s] = r_q;
    end

    assign OutValid = w_stage[LATENCY-1].valid;
    assign OutId    = w_stage[LATENCY-1].id;
    assign OutData  = w_stage[LATENCY-1].data;

endmodule

`default_nettype wire

// File: tb/tb_rr_sreg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_sreg_arbiter
//  Description : Directed self-checking bench for rr_sreg_arbiter. A
//                LATENCY=2 instance is the main target; a LATENCY=1
//                instance shares the same inputs for the latency check.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rr_sreg_arbiter;

    logic        Clk;
    logic        Rst;
    logic [3:0]  Req;
    logic [31:0] ReqData;
    logic        OutReady;

    logic [3:0]        Gnt;
    logic              OutValid;
    logic [1:0]        OutId;
    logic signed [7:0] OutData;

    logic [3:0]        Gnt1;
    logic              OutValid1;
    logic [1:0]        OutId1;
    logic signed [7:0] OutData1;

    int n_checks = 0;
    int n_pass   = 0;

    rr_sreg_arbiter #(.DATAWIDTH(8), .NREQ(4), .LATENCY(2)) u_dut (
        .Clk(Clk), .Rst(Rst), .Req(Req), .ReqData(ReqData), .Gnt(Gnt),
        .OutValid(OutValid), .OutReady(OutReady), .OutId(OutId), .OutData(OutData)
    );

    rr_sreg_arbiter #(.DATAWIDTH(8), .NREQ(4), .LATENCY(1)) u_dut1 (
        .Clk(Clk), .Rst(Rst), .Req(Req), .ReqData(ReqData), .Gnt(Gnt1),
        .OutValid(OutValid1), .OutReady(OutReady), .OutId(OutId1), .OutData(OutData1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_d(input int i, input logic [7:0] v);
        ReqData[i*8 +: 8] = v;
    endtask

    task automatic apply_reset();
        Req = 4'h0;
        Rst = 1'b1;
        step();
        Rst = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1; Req = 4'hF; OutReady = 1'b1; ReqData = '0;
        step();
        #1;
        n_checks++; if (OutValid !== 1'b0) $display("FAIL rst_valid: got %b exp 0", OutValid); else n_pass++;
        n_checks++; if (OutId !== 2'd0) $display("FAIL rst_id: got %0d exp 0", OutId); else n_pass++;
        n_checks++; if (OutData !== 8'h00) $display("FAIL rst_data: got %h exp 00", OutData); else n_pass++;
        n_checks++; if (Gnt !== 4'b0000) $display("FAIL rst_gnt_held: got %b exp 0000", Gnt); else n_pass++;
        // Release and put two items in flight.
        step();
        Rst = 1'b0;
        #1;
        n_checks++; if (Gnt !== 4'b0001) $display("FAIL rst_first_gnt: got %b exp 0001", Gnt); else n_pass++;
        step();
        step();
        n_checks++; if (OutValid !== 1'b1) $display("FAIL rst_inflight_valid: got %b exp 1", OutValid); else n_pass++;
        // Asynchronous reset mid-cycle.
        #2 Rst = 1'b1;
        #1;
        n_checks++; if (OutValid !== 1'b0) $display("FAIL rst_async_drop: got %b exp 0", OutValid); else n_pass++;
        n_checks++; if (Gnt !== 4'b0000) $display("FAIL rst_async_gnt: got %b exp 0000", Gnt); else n_pass++;
        Req = 4'h0;
        step();
        Rst = 1'b0;
        Req = 4'b0001; set_d(0, 8'hFB);
        #1;
        n_checks++; if (Gnt !== 4'b0001) $display("FAIL rst_post_gnt: got %b exp 0001", Gnt); else n_pass++;
        step();
        Req = 4'h0;
        #1;
        n_checks++; if (OutValid !== 1'b0) $display("FAIL rst_post_lat1: got %b exp 0", OutValid); else n_pass++;
        step();
        #1;
        n_checks++; if (OutValid !== 1'b1) $display("FAIL rst_post_valid: got %b exp 1", OutValid); else n_pass++;
        n_checks++; if (OutId !== 2'd0) $display("FAIL rst_post_id: got %0d exp 0", OutId); else n_pass++;
        n_checks++; if (OutData !== 8'hFB) $display("FAIL rst_post_data: got %h exp fb", OutData); else n_pass++;
    endtask

    task automatic test_contention();
        logic [3:0] exp_gnt;
        logic [1:0] exp_id;
        logic [7:0] exp_data;
        apply_reset();
        OutReady = 1'b1;
        for (int i = 0; i < 4; i++) set_d(i, 8'(i * 10));
        for (int c = 0; c < 10; c++) begin
            Req = (c < 8) ? 4'hF : 4'h0;
            #1;
            exp_gnt = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
            n_checks++; if (Gnt !== exp_gnt) $display("FAIL cont_gnt[%0d]: got %b exp %b", c, Gnt, exp_gnt); else n_pass++;
            if (c >= 2) begin
                exp_id   = 2'((c - 2) % 4);
                exp_data = 8'(((c - 2) % 4) * 10);
                n_checks++; if (OutValid !== 1'b1) $display("FAIL cont_valid[%0d]: got %b exp 1", c, OutValid); else n_pass++;
                n_checks++; if (OutId !== exp_id) $display("FAIL cont_id[%0d]: got %0d exp %0d", c, OutId, exp_id); else n_pass++;
                n_checks++; if (OutData !== exp_data) $display("FAIL cont_data[%0d]: got %h exp %h", c, OutData, exp_data); else n_pass++;
            end
            step();
        end
        #1;
        n_checks++; if (OutValid !== 1'b0) $display("FAIL cont_drain: got %b exp 0", OutValid); else n_pass++;
    endtask

    task automatic test_wraparound();
        apply_reset();
        OutReady = 1'b1;
        Req = 4'b0100;
        #1;
        n_checks++; if (Gnt !== 4'b0100) $display("FAIL wrap_setup: got %b exp 0100", Gnt); else n_pass++;
        step();
        Req = 4'b0101;
        #1;
        n_checks++; if (Gnt !== 4'b0001) $display("FAIL wrap_gnt0: got %b exp 0001", Gnt); else n_pass++;
        step();
        #1;
        n_checks++; if (Gnt !== 4'b0100) $display("FAIL wrap_gnt2: got %b exp 0100", Gnt); else n_pass++;
        step();
        Req = 4'b1001;
        #1;
        n_checks++; if (Gnt !== 4'b1000) $display("FAIL wrap_ptr3: got %b exp 1000", Gnt); else n_pass++;
        step();
        Req = 4'b1111;
        #1;
        n_checks++; if (Gnt !== 4'b0001) $display("FAIL wrap_ptr0: got %b exp 0001", Gnt); else n_pass++;
    endtask

    task automatic test_back_pressure();
        apply_reset();
        OutReady = 1'b1;
        set_d(0, 8'd11); set_d(1, 8'd22); set_d(2, 8'd33); set_d(3, 8'd44);
        Req = 4'b1111;
        #1;
        n_checks++; if (Gnt !== 4'b0001) $display("FAIL bp_gnt_a: got %b exp 0001", Gnt); else n_pass++;
        step();
        Req = 4'b1110;
        #1;
        n_checks++; if (Gnt !== 4'b0010) $display("FAIL bp_gnt_b: got %b exp 0010", Gnt); else n_pass++;
        step();
        Req = 4'b1100;
        OutReady = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++; if (Gnt !== 4'b0000) $display("FAIL bp_stall_gnt[%0d]: got %b exp 0000", c, Gnt); else n_pass++;
            n_checks++; if (OutValid !== 1'b1) $display("FAIL bp_stall_valid[%0d]: got %b exp 1", c, OutValid); else n_pass++;
            n_checks++; if (OutId !== 2'd0) $display("FAIL bp_stall_id[%0d]: got %0d exp 0", c, OutId); else n_pass++;
            n_checks++; if (OutData !== 8'd11) $display("FAIL bp_stall_data[%0d]: got %h exp 0b", c, OutData); else n_pass++;
            step();
        end
        OutReady = 1'b1;
        #1;
        n_checks++; if (Gnt !== 4'b0100) $display("FAIL bp_resume_gnt: got %b exp 0100", Gnt); else n_pass++;
        n_checks++; if (OutData !== 8'd11) $display("FAIL bp_resume_data: got %h exp 0b", OutData); else n_pass++;
        step();
        Req = 4'b1000;
        #1;
        n_checks++; if (Gnt !== 4'b1000) $display("FAIL bp_gnt_d: got %b exp 1000", Gnt); else n_pass++;
        n_checks++; if (OutId !== 2'd1 || OutData !== 8'd22) $display("FAIL bp_item1: got %0d/%h exp 1/16", OutId, OutData); else n_pass++;
        step();
        Req = 4'b0000;
        #1;
        n_checks++; if (OutId !== 2'd2 || OutData !== 8'd33) $display("FAIL bp_item2: got %0d/%h exp 2/21", OutId, OutData); else n_pass++;
        step();
        #1;
        n_checks++; if (OutValid !== 1'b1 || OutId !== 2'd3 || OutData !== 8'd44) $display("FAIL bp_item3: got %b/%0d/%h exp 1/3/2c", OutValid, OutId, OutData); else n_pass++;
        step();
        #1;
        n_checks++; if (OutValid !== 1'b0) $display("FAIL bp_no_dup: got %b exp 0", OutValid); else n_pass++;
    endtask

    task automatic test_bubble_head();
        apply_reset();
        OutReady = 1'b0;
        set_d(2, 8'd77);
        Req = 4'b0100;
        #1;
        n_checks++; if (Gnt !== 4'b0100) $display("FAIL bub_gnt: got %b exp 0100", Gnt); else n_pass++;
        step();
        Req = 4'b0000;
        step();
        Req = 4'b0001;
        #1;
        n_checks++; if (OutValid !== 1'b1 || OutId !== 2'd2 || OutData !== 8'd77) $display("FAIL bub_out: got %b/%0d/%h exp 1/2/4d", OutValid, OutId, OutData); else n_pass++;
        n_checks++; if (Gnt !== 4'b0000) $display("FAIL bub_stall_gnt: got %b exp 0000", Gnt); else n_pass++;
        OutReady = 1'b1;
        Req = 4'b0000;
        step();
    endtask

    task automatic test_extremes();
        apply_reset();
        OutReady = 1'b1;
        set_d(0, 8'h80); set_d(1, 8'h7F);
        Req = 4'b0001;
        #1;
        n_checks++; if (Gnt !== 4'b0001 || Gnt1 !== 4'b0001) $display("FAIL ext_gnt: got %b/%b exp 0001/0001", Gnt, Gnt1); else n_pass++;
        step();
        Req = 4'b0010;
        #1;
        n_checks++; if (OutValid1 !== 1'b1 || OutId1 !== 2'd0 || OutData1 !== 8'h80) $display("FAIL ext_lat1_a: got %b/%0d/%h exp 1/0/80", OutValid1, OutId1, OutData1); else n_pass++;
        n_checks++; if (OutValid !== 1'b0) $display("FAIL ext_lat2_early: got %b exp 0", OutValid); else n_pass++;
        step();
        Req = 4'b0000;
        #1;
        n_checks++; if (OutValid !== 1'b1 || OutId !== 2'd0 || OutData !== 8'h80) $display("FAIL ext_min: got %b/%0d/%h exp 1/0/80", OutValid, OutId, OutData); else n_pass++;
        n_checks++; if (OutValid1 !== 1'b1 || OutId1 !== 2'd1 || OutData1 !== 8'h7F) $display("FAIL ext_lat1_b: got %b/%0d/%h exp 1/1/7f", OutValid1, OutId1, OutData1); else n_pass++;
        step();
        #1;
        n_checks++; if (OutValid !== 1'b1 || OutId !== 2'd1 || OutData !== 8'h7F) $display("FAIL ext_max: got %b/%0d/%h exp 1/1/7f", OutValid, OutId, OutData); else n_pass++;
        n_checks++; if (OutValid1 !== 1'b0) $display("FAIL ext_lat1_drain: got %b exp 0", OutValid1); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_contention();
        test_wraparound();
        test_back_pressure();
        test_bubble_head();
        test_extremes();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rr_sreg_arbiter.md
# rr_sreg_arbiter

Round-robin arbiter sharing one pipelined signed register chain between NREQ requesters in generated datapaths. It grants at most one requester per cycle and launches that requester's operand into a LATENCY-deep register pipeline. It returns the value tagged with the requester index, with output back-pressure. It sits between the generated datapath's producer nodes and a single shared storage/delay resource, so that N logical registers cost one physical chain.

## Interface
- DATAWIDTH, 8, width of every operand and result (signed)
- NREQ, 4, number of requesters (2..16)
- LATENCY, 2, register stages from grant to OutValid (1..8)
- IDW, $clog2(NREQ), width of requester index
- Clk  in  1  clock; all state updates on its rising edge
- Rst  in  1  reset: asynchronous, active-high
- Req  in  NREQ  per-requester request; held high with data stable until granted
- ReqData  in  NREQ*DATAWIDTH  packed signed operands; requester i at bits [i*DATAWIDTH +: DATAWIDTH]
- Gnt  out  NREQ  one-hot grant, combinational, same cycle as accepted Req
- OutValid  out  1  result valid
- OutReady  in  1  downstream accepts result when high with OutValid
- OutId  out  IDW  index of the requester that owns OutData
- OutData  out  DATAWIDTH  signed result; bit-exact copy of granted ReqData

## Operation
- Priority pointer Ptr (IDW bits) selects the first requester to check.
- Gnt[i] is high iff Req[i] and i is the first set Req at or after Ptr, scanning upward modulo NREQ, and Adv is high.
- Adv = !(OutValid && !OutReady) && !Rst. Gnt is all-zero when Adv is low.
- On a cycle with any Gnt[i] high, stage 1 loads {valid=1, id=i, data=ReqData[i]} and Ptr becomes (i+1) mod NREQ.
- On a cycle with Adv high and no Req, stage 1 loads valid=0 and Ptr is unchanged.
- Pipeline: the stages shift together only when Adv is high. When Adv is low, every stage holds, including bubbles. There is no bubble compaction.
- The last stage drives OutValid, OutId and OutData directly from flops.
- Requesters are starvation-free: with all Req high and OutReady high, Gnt cycles 0,1,...,NREQ-1,0...
- Data is passed unmodified: no extension, no saturation, and sign is preserved.

## Timing
- Reset value of every output flop is 0: OutValid=0, OutId=0, OutData=0. Ptr=0. All stage valids are 0.
- Gnt is 0 while Rst is high.
- Latency: a grant at edge t produces OutValid at edge t+LATENCY, when there are no stalls in between. Each stall cycle adds one cycle.
- Throughput is one grant per cycle while OutReady is held high.
- OutValid=1 with OutReady=0: the outputs hold stable and no grants are issued. Grants resume in the same cycle OutReady rises.
- OutValid=0 with OutReady=0: Adv stays high, so a bubble at the head never blocks.
- Wrap-around: if Ptr=NREQ-1 and only Req[0] is high, Gnt[0] is high and Ptr becomes 1. If Ptr=NREQ-1 and Gnt[NREQ-1] is high, Ptr becomes 0.
- Reset mid-operation: in-flight items are discarded, OutValid drops asynchronously, and Ptr returns to 0. No grant is issued in the cycle Rst deasserts if Rst is still high at that edge.
- A Req dropped before its grant is a protocol violation; it is ignored with no error flag.

## Structure
- Shared package rr_sreg_pkg:
  - function for the IDW computation
  - localparam MAX_NREQ=16
  - pipeline stage struct type {valid, id, data} parameterised via DATAWIDTH/IDW macros
- Sub-module rr_pick:
  - purely combinational rotate / priority-encode / rotate-back
  - inputs Req and Ptr; outputs one-hot Gnt and binary GntId
- The top module holds Ptr, the stage array (generate loop over LATENCY), and the Adv logic.

## Test plan
- Reset: Rst pulsed mid-stream with 2 items in flight -> OutValid=0 immediately; after release, Req=4'b0001 with data -5 -> OutValid at t+2, OutId=0, OutData=-5 (8'hFB).
- Full contention, NREQ=4: all Req high, data i*10, OutReady=1 for 8 cycles -> Gnt sequence 1,2,4,8,1,2,4,8; OutId sequence 0,1,2,3,0,1,2,3 starting 2 cycles later.
- Wrap-around: Ptr=3, Req=4'b0101 -> Gnt=4'b0001; next cycle Gnt=4'b0100; Ptr=3 after.
- Back-pressure: stream 4 items, OutReady low for 3 cycles while OutValid=1 -> OutData/OutId stable, Gnt=0 for 3 cycles, no item lost or duplicated, order preserved.
- Bubble head: OutValid=0, OutReady=0, Req[2] high -> Gnt=4'b0100 granted immediately.
- Extremes: DATAWIDTH=8, operands -128 and 127 -> returned bit-exact; LATENCY=1 build -> OutValid one cycle after grant.
